// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: states, opcodes,
// function codes, ALU-op classes and datapath select values.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_SEXT   = 2'b10;
    localparam logic [1:0] SRCB_SEXTSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LB) || (op == OP_SB) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_controller_alucontrol.sv
// ALU-control decoder: maps the controller's ALU-op class and the R-type
// function field onto the 3-bit ALU operation.
module alucontrol
    import mc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucont
);

    always_comb begin
        alucont = 3'b010;
        case (aluop)
            ALUOP_ADD: alucont = 3'b010;
            ALUOP_SUB: alucont = 3'b110;
            default: begin
                case (funct)
                    FN_ADD:  alucont = 3'b010;
                    FN_SUB:  alucont = 3'b110;
                    FN_AND:  alucont = 3'b000;
                    FN_OR:   alucont = 3'b001;
                    FN_SLT:  alucont = 3'b111;
                    default: alucont = 3'b010;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM for the MIPS-subset datapath; outputs are decoded from
// the current state and mem_ready, and memory accesses stall on mem_ready.
module mc_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       irwrite,
    output logic       iord,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [2:0] alucont,
    output logic       illegal_op
);

    state_t     state;
    logic [1:0] aluop;
    logic       pcwrite;
    logic       branch;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:   if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LB, OP_SB: state <= S_MEMADR;
                        OP_RTYPE:     state <= S_RTYPEEX;
                        OP_BEQ:       state <= S_BEQEX;
                        OP_ADDI:      state <= S_ADDIEX;
                        OP_J:         state <= S_JEX;
                        default:      state <= S_FETCH;
                    endcase
                end
                S_MEMADR:  state <= (op == OP_SB) ? S_MEMWR : S_MEMRD;
                S_MEMRD:   if (mem_ready) state <= S_MEMWB;
                S_MEMWR:   if (mem_ready) state <= S_FETCH;
                S_RTYPEEX: state <= S_RTYPEWB;
                S_ADDIEX:  state <= S_ADDIWB;
                default:   state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_B;
        pcsrc      = PCSRC_ALU;
        aluop      = ALUOP_ADD;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        illegal_op = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                alusrcb = SRCB_FOUR;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            S_DECODE: begin
                alusrcb    = SRCB_SEXTSH;
                illegal_op = !op_legal(op);
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_SEXT;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = PCSRC_ALUOUT;
                branch  = 1'b1;
            end
            S_ADDIWB:  regwrite = 1'b1;
            S_JEX: begin
                pcsrc   = PCSRC_JUMP;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
        // Enables stay quiet for the whole reset pulse even though FETCH would request memory.
        if (!reset_n) begin
            mem_req    = 1'b0;
            memwrite   = 1'b0;
            irwrite    = 1'b0;
            regwrite   = 1'b0;
            pcwrite    = 1'b0;
            branch     = 1'b0;
            illegal_op = 1'b0;
        end
    end

    assign pcen = pcwrite | (branch & zero);

    alucontrol u_alucontrol (
        .aluop   (aluop),
        .funct   (funct),
        .alucont (alucont)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller: each instruction is expanded into its
// expected per-cycle control pattern and compared cycle by cycle.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, memwrite, irwrite, iord, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       pcen;
    logic [2:0] alucont;
    logic       illegal_op;

    int n_vec  = 0;
    int n_miss = 0;

    localparam int K_LB = 0, K_SB = 1, K_R = 2, K_BEQ = 3, K_ADDI = 4, K_J = 5, K_ILL = 6;

    typedef struct packed {
        logic       ready;
        logic       zero;
        logic       mem_req, memwrite, irwrite, iord, regdst, memtoreg, regwrite, alusrca;
        logic [1:0] srcb, pcsrc;
        logic       pcen;
        logic [2:0] alucont;
        logic       illegal;
    } row_t;

    row_t q[$];

    mc_controller dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite),
        .irwrite(irwrite), .iord(iord), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .pcen(pcen), .alucont(alucont), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %05h expected %05h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [16:0] dut_vec();
        return {mem_req, memwrite, irwrite, iord, regdst, memtoreg, regwrite, alusrca,
                alusrcb, pcsrc, pcen, alucont, illegal_op};
    endfunction

    function automatic logic [16:0] row_vec(input row_t r);
        return {r.mem_req, r.memwrite, r.irwrite, r.iord, r.regdst, r.memtoreg, r.regwrite,
                r.alusrca, r.srcb, r.pcsrc, r.pcen, r.alucont, r.illegal};
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic [5:0] op_of(input int k);
        logic [5:0] o;
        case (k)
            K_LB:   return 6'b100000;
            K_SB:   return 6'b101000;
            K_R:    return 6'b000000;
            K_BEQ:  return 6'b000100;
            K_ADDI: return 6'b001000;
            K_J:    return 6'b000010;
            default: begin
                do o = 6'($urandom);
                while (o == 6'b100000 || o == 6'b101000 || o == 6'b000000 ||
                       o == 6'b000100 || o == 6'b001000 || o == 6'b000010);
                return o;
            end
        endcase
    endfunction

    // Every unlisted output is 0 and the add operation is selected by default;
    // mem_ready and zero are random where they should not matter.
    function automatic row_t blank();
        row_t r;
        r = '0;
        r.srcb    = 2'b00;
        r.alucont = 3'b010;
        r.ready   = 1'($urandom);
        r.zero    = 1'($urandom);
        return r;
    endfunction

    task automatic gen_fetch(input int stalls);
        row_t r;
        for (int i = 0; i <= stalls; i++) begin
            r = blank();
            r.ready   = (i == stalls);
            r.mem_req = 1'b1;
            r.srcb    = 2'b01;
            r.irwrite = r.ready;
            r.pcen    = r.ready;
            q.push_back(r);
        end
    endtask

    task automatic gen_decode(input logic bad);
        row_t r;
        r = blank();
        r.srcb    = 2'b11;
        r.illegal = bad;
        q.push_back(r);
    endtask

    task automatic gen_exec(input int k, input logic [5:0] f, input logic z, input int mst);
        row_t r;
        case (k)
            K_LB, K_SB: begin
                r = blank(); r.alusrca = 1'b1; r.srcb = 2'b10; q.push_back(r);
                for (int i = 0; i <= mst; i++) begin
                    r = blank();
                    r.ready    = (i == mst);
                    r.mem_req  = 1'b1;
                    r.iord     = 1'b1;
                    r.memwrite = (k == K_SB);
                    q.push_back(r);
                end
                if (k == K_LB) begin
                    r = blank(); r.memtoreg = 1'b1; r.regwrite = 1'b1; q.push_back(r);
                end
            end
            K_R: begin
                r = blank(); r.alusrca = 1'b1; r.alucont = alu_of(f); q.push_back(r);
                r = blank(); r.regdst = 1'b1; r.regwrite = 1'b1; q.push_back(r);
            end
            K_BEQ: begin
                r = blank(); r.alusrca = 1'b1; r.alucont = 3'b110; r.pcsrc = 2'b01;
                r.zero = z; r.pcen = z; q.push_back(r);
            end
            K_ADDI: begin
                r = blank(); r.alusrca = 1'b1; r.srcb = 2'b10; q.push_back(r);
                r = blank(); r.regwrite = 1'b1; q.push_back(r);
            end
            K_J: begin
                r = blank(); r.pcsrc = 2'b10; r.pcen = 1'b1; q.push_back(r);
            end
            default: ;
        endcase
    endtask

    // Entered and left at posedge+1; outputs are sampled at posedge+4.
    task automatic run_q(input string tag);
        row_t r;
        int   i;
        i = 0;
        while (q.size() > 0) begin
            r = q.pop_front();
            mem_ready = r.ready;
            zero      = r.zero;
            #3;
            check_vec($sformatf("%s[%0d]", tag, i), dut_vec(), row_vec(r));
            @(posedge clk);
            #1;
            i++;
        end
    endtask

    task automatic do_instr(input string tag, input int k, input logic [5:0] f,
                            input logic z, input int fst, input int mst);
        op    = op_of(k);
        funct = f;
        gen_fetch(fst);
        gen_decode(k == K_ILL);
        gen_exec(k, f, z, mst);
        run_q(tag);
    endtask

    function automatic logic [16:0] reset_vec();
        row_t r;
        r = '0;
        r.srcb    = 2'b01;
        r.alucont = 3'b010;
        return row_vec(r);
    endfunction

    logic [5:0] fn_tab [5];

    initial begin
        fn_tab[0] = 6'b100000; fn_tab[1] = 6'b100010; fn_tab[2] = 6'b100100;
        fn_tab[3] = 6'b100101; fn_tab[4] = 6'b101010;
        reset_n = 1'b0; op = 6'b000000; funct = 6'b100000; zero = 1'b1; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #4;
        check_vec("reset_hold", dut_vec(), reset_vec());
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        do_instr("radd", K_R, 6'b100000, 1'b0, 0, 0);
        do_instr("lb_stall3", K_LB, 6'b000000, 1'b0, 0, 3);
        do_instr("beq_z1", K_BEQ, 6'b000000, 1'b1, 0, 0);
        do_instr("beq_z0", K_BEQ, 6'b000000, 1'b0, 0, 0);
        do_instr("sb_stall2", K_SB, 6'b000000, 1'b0, 0, 2);
        op = 6'b111111; funct = 6'b000000;
        gen_fetch(0); gen_decode(1'b1); run_q("ill_3f");
        do_instr("j", K_J, 6'b000000, 1'b0, 1, 0);
        do_instr("addi", K_ADDI, 6'b000000, 1'b0, 0, 0);

        // Abandon an R-type in its execute cycle with an asynchronous reset pulse.
        op = 6'b000000; funct = 6'b100010;
        gen_fetch(0); gen_decode(1'b0); run_q("rst_pre");
        #1;
        reset_n = 1'b0;
        mem_ready = 1'b1;
        zero = 1'b1;
        #1;
        check_vec("rst_mid_rtypeex", dut_vec(), reset_vec());
        @(posedge clk);
        #3;
        check_vec("rst_mid_hold", dut_vec(), reset_vec());
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        do_instr("rst_post", K_ADDI, 6'b000000, 1'b0, 2, 0);

        for (int n = 0; n < 150; n++) begin
            int k;
            k = int'($urandom_range(0, 6));
            do_instr($sformatf("rnd%0d_k%0d", n, k), k, fn_tab[$urandom_range(0, 4)],
                     1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
